// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store data-memory master.
// Build option: LSU_MISALIGN_SPLIT_EN selects splitting of word-crossing accesses.
package lsu_pkg;

   localparam logic [2:0] SIZE_B = 3'b001;
   localparam logic [2:0] SIZE_H = 3'b010;
   localparam logic [2:0] SIZE_W = 3'b100;

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

   // Priority decode: widest set bit wins, zero-hot falls back to a byte.
   function automatic logic [2:0] size_norm(input logic [2:0] size);
      if (size[2])      return SIZE_W;
      else if (size[1]) return SIZE_H;
      else              return SIZE_B;
   endfunction

   function automatic logic [3:0] size_mask(input logic [2:0] size);
      case (size_norm(size))
         SIZE_W:  return 4'hF;
         SIZE_H:  return 4'h3;
         default: return 4'h1;
      endcase
   endfunction

   function automatic logic is_cross(input logic [2:0] size, input logic [1:0] off);
      return ((size_norm(size) == SIZE_W) && (off != 2'd0)) ||
             ((size_norm(size) == SIZE_H) && (off == 2'd3));
   endfunction

endpackage

// File: rtl/lsu_dmem_master_if.sv
// Core request/response and RAM port bundle of the data-memory master.
// master = the LSU itself, slave = the core/RAM environment around it.
interface lsu_dmem_master_if #(parameter int RAM_AW = 9) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic [2:0]        req_size;
   logic              req_se;

   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   logic              ram_en;
   logic              ram_we;
   logic [3:0]        ram_be;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_size, req_se, ram_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             ram_en, ram_we, ram_be, ram_addr, ram_wdata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_size, req_se, ram_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             ram_en, ram_we, ram_be, ram_addr, ram_wdata
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: store data/byte-mask shift over a two-word window,
// load data shift-down, truncation and zero/sign extension.
import lsu_pkg::*;

module lsu_align (
   input  logic [1:0]  off,
   input  logic [2:0]  size,
   input  logic        se,
   input  logic [31:0] wdata,
   input  logic [31:0] rd0,
   input  logic [31:0] rd1,
   output logic [3:0]  be0,
   output logic [3:0]  be1,
   output logic [31:0] wlo,
   output logic [31:0] whi,
   output logic [31:0] rdata
);

   logic [7:0]  mask;
   logic [63:0] wshift;
   logic [63:0] rshift;

   assign mask         = {4'b0000, size_mask(size)} << off;
   assign {be1, be0}   = mask;
   assign wshift       = {32'b0, wdata} << {off, 3'b000};
   assign {whi, wlo}   = wshift;
   assign rshift       = {rd1, rd0} >> {off, 3'b000};

   always_comb begin
      // NOTE: default assignment first so every path drives rdata and no latch is inferred.
      rdata = rshift[31:0];
      case (size_norm(size))
         SIZE_H:  rdata = {{16{se & rshift[15]}}, rshift[15:0]};
         SIZE_B:  rdata = {{24{se & rshift[7]}},  rshift[7:0]};
         default: rdata = rshift[31:0];
      endcase
   end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store initiator onto a single-port synchronous RAM with byte enables.
// Build option LSU_MISALIGN_SPLIT_EN: split word-crossing accesses instead of rejecting them.
import lsu_pkg::*;

module lsu_dmem_master #(
   parameter int RAM_AW = 9
) (
   input  logic                  clock,
   input  logic                  reset_n,
   lsu_dmem_master_if.master     bus
);

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   localparam int AW = RAM_AW + 2;

   state_t            state;
   logic              r_write;
   logic              r_se;
   logic              r_cross;
   logic [AW-1:0]     r_addr;
   logic [31:0]       r_wdata;
   logic [2:0]        r_size;
   logic [31:0]       rd0;

   logic              idle;
   logic [AW-1:0]     a_addr;
   logic [31:0]       a_wdata;
   logic [2:0]        a_size;
   logic              a_cross;
   logic [RAM_AW-1:0] w0;
   logic [RAM_AW-1:0] w1;
   logic [3:0]        be0;
   logic [3:0]        be1;
   logic [31:0]       wlo;
   logic [31:0]       whi;
   logic [31:0]       rd_ext;
   logic              unused_addr_hi;

   // The first RAM cycle is launched on the accept edge, so alignment sees
   // the live request while idle and the latched copy afterwards.
   assign idle    = (state == IDLE);
   assign a_addr  = idle ? bus.req_addr[AW-1:0] : r_addr;
   assign a_wdata = idle ? bus.req_wdata        : r_wdata;
   assign a_size  = idle ? bus.req_size         : r_size;
   assign a_cross = is_cross(a_size, a_addr[1:0]);
   assign w0      = a_addr[AW-1:2];
   assign w1      = w0 + {{(RAM_AW-1){1'b0}}, 1'b1};

   assign unused_addr_hi = ^bus.req_addr[31:AW];

   lsu_align u_align (
      .off   (a_addr[1:0]),
      .size  (a_size),
      .se    (r_se),
      .wdata (a_wdata),
      .rd0   (r_cross ? rd0 : bus.ram_rdata),
      .rd1   (bus.ram_rdata),
      .be0   (be0),
      .be1   (be1),
      .wlo   (wlo),
      .whi   (whi),
      .rdata (rd_ext)
   );

   assign bus.rsp_rdata = (bus.rsp_valid && !bus.rsp_err && !r_write) ? rd_ext : 32'b0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.ram_en    <= 1'b0;
         bus.ram_we    <= 1'b0;
         bus.ram_be    <= '0;
         bus.ram_addr  <= '0;
         bus.ram_wdata <= '0;
         r_write       <= 1'b0;
         r_se          <= 1'b0;
         r_cross       <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_size        <= '0;
         rd0           <= '0;
      end else begin
         // NOTE: non-blocking assignments everywhere so each decision uses pre-edge state.
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.ram_en    <= 1'b0;
         bus.ram_we    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_write       <= bus.req_write;
                  r_se          <= bus.req_se;
                  r_cross       <= a_cross;
                  r_addr        <= a_addr;
                  r_wdata       <= bus.req_wdata;
                  r_size        <= bus.req_size;
                  bus.req_ready <= 1'b0;
                  if (a_cross && !SPLIT_EN) begin
                     state         <= DONE;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                  end else begin
                     state         <= ACC0;
                     bus.ram_en    <= 1'b1;
                     bus.ram_we    <= bus.req_write;
                     bus.ram_be    <= be0;
                     bus.ram_addr  <= w0;
                     bus.ram_wdata <= wlo;
                  end
               end
            end
            ACC0: begin
               if (r_cross) begin
                  state         <= ACC1;
                  bus.ram_en    <= 1'b1;
                  bus.ram_we    <= r_write;
                  bus.ram_be    <= be1;
                  bus.ram_addr  <= w1;
                  bus.ram_wdata <= whi;
               end else begin
                  state         <= DONE;
                  bus.rsp_valid <= 1'b1;
               end
            end
            ACC1: begin
               rd0           <= bus.ram_rdata;
               state         <= DONE;
               bus.rsp_valid <= 1'b1;
            end
            DONE: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master: accept monitor pushes expectations,
// separate response and RAM monitors pop and compare.
import lsu_pkg::*;

module tb_lsu_dmem_master;

   localparam int RAM_AW = 9;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [8:0]  addr;
      logic [31:0] wdata;
   } acc_t;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          n_acc;
      acc_t        a0;
      acc_t        a1;
      int          acc_cyc;
   } exp_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   lsu_dmem_master_if #(.RAM_AW(RAM_AW)) bus ();

   lsu_dmem_master #(.RAM_AW(RAM_AW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   int   n_tests   = 0;
   int   n_fail    = 0;
   int   cyc       = 0;
   int   acc_count = 0;
   exp_t exp_q[$];
   acc_t ram_q[$];
   exp_t cur;
   exp_t acc_e;
   exp_t rsp_e;
   acc_t ram_a;
   logic [31:0] mem [512];

   localparam acc_t NA = '0;

   function automatic acc_t acc(input logic we, input logic [3:0] be,
                                input logic [8:0] addr, input logic [31:0] wd);
      acc_t a;
      a.we = we; a.be = be; a.addr = addr; a.wdata = wd;
      return a;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // RAM model: synchronous read, byte-enabled write.
   always @(posedge clock) begin
      cyc++;
      if (bus.ram_en) begin
         if (bus.ram_we) begin
            for (int i = 0; i < 4; i++)
               if (bus.ram_be[i]) mem[bus.ram_addr][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
         end else begin
            bus.ram_rdata <= mem[bus.ram_addr];
         end
      end
   end

   // Accept monitor: every handshake pushes the current expectation.
   always @(negedge clock) begin
      if (reset_n && bus.req_valid && bus.req_ready) begin
         acc_e         = cur;
         acc_e.acc_cyc = cyc;
         exp_q.push_back(acc_e);
         if (cur.n_acc > 0) ram_q.push_back(cur.a0);
         if (cur.n_acc > 1) ram_q.push_back(cur.a1);
         acc_count++;
      end
   end

   // Response monitor.
   always @(negedge clock) begin
      if (bus.rsp_valid) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", {31'b0, bus.rsp_valid}, 32'd0);
         end else begin
            rsp_e = exp_q.pop_front();
            check({rsp_e.tag, "_rdata"},   bus.rsp_rdata, rsp_e.rdata);
            check({rsp_e.tag, "_err"},     {31'b0, bus.rsp_err}, {31'b0, rsp_e.err});
            check({rsp_e.tag, "_latency"}, cyc - rsp_e.acc_cyc, rsp_e.lat);
         end
      end
   end

   // RAM access monitor.
   always @(negedge clock) begin
      if (bus.ram_en) begin
         if (ram_q.size() == 0) begin
            check("ram_unexpected", {31'b0, bus.ram_en}, 32'd0);
         end else begin
            ram_a = ram_q.pop_front();
            check("ram_we",   {31'b0, bus.ram_we}, {31'b0, ram_a.we});
            check("ram_be",   {28'b0, bus.ram_be}, {28'b0, ram_a.be});
            check("ram_addr", {23'b0, bus.ram_addr}, {23'b0, ram_a.addr});
            if (ram_a.we) check("ram_wdata", bus.ram_wdata, ram_a.wdata);
         end
      end else if (bus.ram_we) begin
         check("ram_we_without_en", {31'b0, bus.ram_we}, 32'd0);
      end
   end

   task automatic set_req(input string tag, input logic w, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] size, input logic se,
                          input logic [31:0] rdata, input logic err, input int lat,
                          input int n_acc, input acc_t a0, input acc_t a1);
      cur.tag   = tag;   cur.rdata = rdata; cur.err = err; cur.lat = lat;
      cur.n_acc = n_acc; cur.a0    = a0;    cur.a1  = a1;  cur.acc_cyc = 0;
      bus.req_write = w;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_size  = size;
      bus.req_se    = se;
   endtask

   task automatic send_wait(input string tag);
      int base;
      int n;
      base = acc_count;
      n    = 0;
      bus.req_valid = 1'b1;
      while (acc_count == base && n < 20) begin
         @(posedge clock); #2;
         n++;
      end
      bus.req_valid = 1'b0;
      check({tag, "_accepted"}, acc_count - base, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || ram_q.size() != 0) && n < 20) begin
         @(posedge clock); #2;
         n++;
      end
      check("drain", exp_q.size() + ram_q.size(), 0);
   endtask

   task automatic run(input string tag, input logic w, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] size, input logic se,
                      input logic [31:0] rdata, input logic err, input int lat,
                      input int n_acc, input acc_t a0, input acc_t a1);
      set_req(tag, w, addr, wdata, size, se, rdata, err, lat, n_acc, a0, a1);
      send_wait(tag);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_size  = '0;
      bus.req_se    = 1'b0;
      cur           = '{tag: "none", rdata: '0, err: 1'b0, lat: 0, n_acc: 0, a0: NA, a1: NA, acc_cyc: 0};

      repeat (3) @(posedge clock);
      #2;
      check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_err",   {31'b0, bus.rsp_err},   32'd0);
      check("rst_ram_en",    {31'b0, bus.ram_en},    32'd0);
      check("rst_ram_we",    {31'b0, bus.ram_we},    32'd0);
      check("rst_ram_be",    {28'b0, bus.ram_be},    32'd0);
      check("rst_ram_addr",  {23'b0, bus.ram_addr},  32'd0);
      check("rst_ram_wdata", bus.ram_wdata,          32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata,          32'd0);
      reset_n = 1'b1;
      @(posedge clock); #2;

      // 1: aligned word store and load
      run("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, SIZE_W, 1'b0, 32'h0, 1'b0, 2, 1,
          acc(1'b1, 4'hF, 9'd4, 32'hDEADBEEF), NA);
      run("lw_10", 1'b0, 32'h10, 32'h0, SIZE_W, 1'b0, 32'hDEADBEEF, 1'b0, 2, 1,
          acc(1'b0, 4'hF, 9'd4, 32'h0), NA);

      // 2: sub-word loads with extension, stores into lanes, size decode corners
      run("sw_80", 1'b1, 32'h10, 32'h80000000, SIZE_W, 1'b0, 32'h0, 1'b0, 2, 1,
          acc(1'b1, 4'hF, 9'd4, 32'h80000000), NA);
      run("lb_13_se", 1'b0, 32'h13, 32'h0, SIZE_B, 1'b1, 32'hFFFFFF80, 1'b0, 2, 1,
          acc(1'b0, 4'h8, 9'd4, 32'h0), NA);
      run("lb_13_ze", 1'b0, 32'h13, 32'h0, SIZE_B, 1'b0, 32'h00000080, 1'b0, 2, 1,
          acc(1'b0, 4'h8, 9'd4, 32'h0), NA);
      run("lh_12_se", 1'b0, 32'h12, 32'h0, SIZE_H, 1'b1, 32'hFFFF8000, 1'b0, 2, 1,
          acc(1'b0, 4'hC, 9'd4, 32'h0), NA);
      run("lw_hi_addr", 1'b0, 32'hF0000010, 32'h0, SIZE_W, 1'b0, 32'h80000000, 1'b0, 2, 1,
          acc(1'b0, 4'hF, 9'd4, 32'h0), NA);
      run("sh_11", 1'b1, 32'h11, 32'hA5A51234, SIZE_H, 1'b0, 32'h0, 1'b0, 2, 1,
          acc(1'b1, 4'h6, 9'd4, 32'hA5123400), NA);
      run("lw_after_sh", 1'b0, 32'h10, 32'h0, SIZE_W, 1'b0, 32'h80123400, 1'b0, 2, 1,
          acc(1'b0, 4'hF, 9'd4, 32'h0), NA);
      run("sb_12", 1'b1, 32'h12, 32'h000000FF, SIZE_B, 1'b0, 32'h0, 1'b0, 2, 1,
          acc(1'b1, 4'h4, 9'd4, 32'h00FF0000), NA);
      run("lh_11_ze", 1'b0, 32'h11, 32'h0, SIZE_H, 1'b0, 32'h0000FF34, 1'b0, 2, 1,
          acc(1'b0, 4'h6, 9'd4, 32'h0), NA);
      run("lh_11_se", 1'b0, 32'h11, 32'h0, SIZE_H, 1'b1, 32'hFFFFFF34, 1'b0, 2, 1,
          acc(1'b0, 4'h6, 9'd4, 32'h0), NA);
      run("l_size0", 1'b0, 32'h12, 32'h0, 3'b000, 1'b0, 32'h000000FF, 1'b0, 2, 1,
          acc(1'b0, 4'h4, 9'd4, 32'h0), NA);
      run("l_size110", 1'b0, 32'h10, 32'h0, 3'b110, 1'b0, 32'h80FF3400, 1'b0, 2, 1,
          acc(1'b0, 4'hF, 9'd4, 32'h0), NA);

      // 3: word-crossing store/loads
`ifdef LSU_MISALIGN_SPLIT_EN
      run("sw_0e", 1'b1, 32'h0E, 32'h11223344, SIZE_W, 1'b0, 32'h0, 1'b0, 3, 2,
          acc(1'b1, 4'hC, 9'd3, 32'h33440000), acc(1'b1, 4'h3, 9'd4, 32'h00001122));
      run("lw_0e", 1'b0, 32'h0E, 32'h0, SIZE_W, 1'b0, 32'h11223344, 1'b0, 3, 2,
          acc(1'b0, 4'hC, 9'd3, 32'h0), acc(1'b0, 4'h3, 9'd4, 32'h0));
      run("lh_0f", 1'b0, 32'h0F, 32'h0, SIZE_H, 1'b0, 32'h00002233, 1'b0, 3, 2,
          acc(1'b0, 4'h8, 9'd3, 32'h0), acc(1'b0, 4'h1, 9'd4, 32'h0));
`else
      run("sw_0e", 1'b1, 32'h0E, 32'h11223344, SIZE_W, 1'b0, 32'h0, 1'b1, 1, 0, NA, NA);
      run("lw_0e", 1'b0, 32'h0E, 32'h0, SIZE_W, 1'b0, 32'h0, 1'b1, 1, 0, NA, NA);
      run("lh_0f", 1'b0, 32'h0F, 32'h0, SIZE_H, 1'b0, 32'h0, 1'b1, 1, 0, NA, NA);
`endif

      // 4: top-of-memory wrap
      run("sw_7fc", 1'b1, 32'h7FC, 32'hAABBCCDD, SIZE_W, 1'b0, 32'h0, 1'b0, 2, 1,
          acc(1'b1, 4'hF, 9'd511, 32'hAABBCCDD), NA);
      run("sw_000", 1'b1, 32'h000, 32'h01020384, SIZE_W, 1'b0, 32'h0, 1'b0, 2, 1,
          acc(1'b1, 4'hF, 9'd0, 32'h01020384), NA);
      run("lb_7ff", 1'b0, 32'h7FF, 32'h0, SIZE_B, 1'b0, 32'h000000AA, 1'b0, 2, 1,
          acc(1'b0, 4'h8, 9'd511, 32'h0), NA);
`ifdef LSU_MISALIGN_SPLIT_EN
      run("lh_7ff", 1'b0, 32'h7FF, 32'h0, SIZE_H, 1'b1, 32'hFFFF84AA, 1'b0, 3, 2,
          acc(1'b0, 4'h8, 9'd511, 32'h0), acc(1'b0, 4'h1, 9'd0, 32'h0));
`else
      run("lh_7ff", 1'b0, 32'h7FF, 32'h0, SIZE_H, 1'b1, 32'h0, 1'b1, 1, 0, NA, NA);
`endif

      // 5: asynchronous reset during the last RAM cycle of an access
`ifdef LSU_MISALIGN_SPLIT_EN
      set_req("rst_mid", 1'b0, 32'h0E, 32'h0, SIZE_W, 1'b0, 32'h0, 1'b0, 3, 2,
              acc(1'b0, 4'hC, 9'd3, 32'h0), acc(1'b0, 4'h3, 9'd4, 32'h0));
      send_wait("rst_mid");
      @(posedge clock); #2;
`else
      set_req("rst_mid", 1'b0, 32'h10, 32'h0, SIZE_W, 1'b0, 32'h0, 1'b0, 2, 1,
              acc(1'b0, 4'hF, 9'd4, 32'h0), NA);
      send_wait("rst_mid");
`endif
      check("rst_mid_pre_en", {31'b0, bus.ram_en}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check("rst_mid_ram_en",    {31'b0, bus.ram_en},    32'd0);
      check("rst_mid_ram_we",    {31'b0, bus.ram_we},    32'd0);
      check("rst_mid_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      exp_q.delete();
      ram_q.delete();
      @(posedge clock);
      @(posedge clock); #2;
      reset_n = 1'b1;
      #1;
      check("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
      @(posedge clock); #2;
      run("sw_post_rst", 1'b1, 32'h10, 32'h5555AAAA, SIZE_W, 1'b0, 32'h0, 1'b0, 2, 1,
          acc(1'b1, 4'hF, 9'd4, 32'h5555AAAA), NA);
      run("lw_post_rst", 1'b0, 32'h10, 32'h0, SIZE_W, 1'b0, 32'h5555AAAA, 1'b0, 2, 1,
          acc(1'b0, 4'hF, 9'd4, 32'h0), NA);

      // 6: request held for 8 cycles is accepted only from IDLE
      set_req("held", 1'b0, 32'h10, 32'h0, SIZE_W, 1'b0, 32'h5555AAAA, 1'b0, 2, 1,
              acc(1'b0, 4'hF, 9'd4, 32'h0), NA);
      n = 0;
      while (!bus.req_ready && n < 10) begin
         @(posedge clock); #2;
         n++;
      end
      base = acc_count;
      bus.req_valid = 1'b1;
      repeat (8) begin
         @(posedge clock); #2;
      end
      bus.req_valid = 1'b0;
      check("held_accepts", acc_count - base, 3);
      drain();

      repeat (3) @(posedge clock);
      #2;
      check("final_exp_q_empty", exp_q.size(), 0);
      check("final_ram_q_empty", ram_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
